// File: rtl/pc_ras.sv
// pc_ras -- fetch-stage program counter with an integrated return-address stack.
//
// Purpose:
//   Holds the current PC that drives the instruction-memory address. Supports
//   hold, increment, signed-relative branch, absolute jump, relative call
//   (push + branch), return (pop) and interrupt-vector entry (push + vector).
//   The return-address stack is a circular buffer. A push while the stack is
//   full overwrites the oldest entry. A pop while it is empty falls through to
//   PC + INC. Each of these cases sets its own sticky error flag.
//
// Ports:
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   en_in          in   update enable (0 = stall, everything holds)
//   ps_in[2:0]     in   PC select opcode
//   ia_in          in   signed branch / call offset
//   ra_in          in   absolute jump target
//   vec_in         in   interrupt vector address
//   err_clr_in     in   clears both sticky error flags (only when en_in=1)
//   pc_out         out  registered current PC
//   ras_cnt_out    out  number of valid stack entries
//   ras_full_out   out  ras_cnt_out == RAS_DEPTH
//   ras_empty_out  out  ras_cnt_out == 0
//   ovf_err_out    out  sticky: push while full
//   unf_err_out    out  sticky: pop while empty

module pc_ras #(
  parameter int              PC_W      = 16,
  parameter int              RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int              INC       = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en_in,
  input  logic [2:0]                     ps_in,
  input  logic [PC_W-1:0]                ia_in,
  input  logic [PC_W-1:0]                ra_in,
  input  logic [PC_W-1:0]                vec_in,
  input  logic                           err_clr_in,
  output logic [PC_W-1:0]                pc_out,
  output logic [$clog2(RAS_DEPTH):0]     ras_cnt_out,
  output logic                           ras_full_out,
  output logic                           ras_empty_out,
  output logic                           ovf_err_out,
  output logic                           unf_err_out
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [PC_W-1:0]  INC_V   = PC_W'(INC);
  localparam logic [CNT_W-1:0] DEPTH_V = CNT_W'(RAS_DEPTH);

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_INC  = 3'b001;
  localparam logic [2:0] OP_BR   = 3'b010;
  localparam logic [2:0] OP_JMP  = 3'b011;
  localparam logic [2:0] OP_CALL = 3'b100;
  localparam logic [2:0] OP_RET  = 3'b101;
  localparam logic [2:0] OP_IRQ  = 3'b110;

  logic [PC_W-1:0]  pc_q,  pc_d;
  logic [PTR_W-1:0] tp_q,  tp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic [PC_W-1:0]  mem_q [RAS_DEPTH];

  logic             push;
  logic [PC_W-1:0]  push_val;
  logic             full, empty;
  logic             ovf_set, unf_set;
  logic [RAS_DEPTH-1:0] wr_en;

  assign full  = (cnt_q == DEPTH_V);
  assign empty = (cnt_q == '0);

  // Next-state decode. Modulo-2^PC_W arithmetic falls out of the fixed width.
  always_comb begin
    pc_d     = pc_q;
    tp_d     = tp_q;
    cnt_d    = cnt_q;
    push     = 1'b0;
    push_val = '0;
    ovf_set  = 1'b0;
    unf_set  = 1'b0;

    unique case (ps_in)
      OP_HOLD: pc_d = pc_q;
      OP_INC:  pc_d = pc_q + INC_V;
      OP_BR:   pc_d = pc_q + ia_in;
      OP_JMP:  pc_d = ra_in;
      OP_CALL: begin
        push     = 1'b1;
        push_val = pc_q + INC_V;
        pc_d     = pc_q + ia_in;
      end
      OP_RET: begin
        if (empty) begin
          pc_d    = pc_q + INC_V;
          unf_set = 1'b1;
        end else begin
          pc_d  = mem_q[tp_q];
          tp_d  = tp_q - 1'b1;
          cnt_d = cnt_q - 1'b1;
        end
      end
      OP_IRQ: begin
        // Push the interrupted PC itself so it is re-fetched on return.
        push     = 1'b1;
        push_val = pc_q;
        pc_d     = vec_in;
      end
      default: pc_d = pc_q;
    endcase

    if (push) begin
      tp_d = tp_q + 1'b1;
      if (full) begin
        // Wrapping tp lands on the oldest entry, which is then overwritten.
        ovf_set = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // A new error event beats a simultaneous clear.
    ovf_d = (ovf_q & ~err_clr_in) | ovf_set;
    unf_d = (unf_q & ~err_clr_in) | unf_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_PC;
      tp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (en_in) begin
      pc_q  <= pc_d;
      tp_q  <= tp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // One write strobe per entry; the push target is the post-increment pointer.
  for (genvar gi = 0; gi < RAS_DEPTH; gi++) begin : g_wr
    assign wr_en[gi] = en_in & push & (tp_d == PTR_W'(gi));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        if (wr_en[i]) mem_q[i] <= push_val;
      end
    end
  end

  assign pc_out        = pc_q;
  assign ras_cnt_out   = cnt_q;
  assign ras_full_out  = full;
  assign ras_empty_out = empty;
  assign ovf_err_out   = ovf_q;
  assign unf_err_out   = unf_q;

endmodule

// File: tb/tb_pc_ras.sv
// tb_pc_ras -- directed-vector bench for pc_ras (PC_W=16, RAS_DEPTH=4, INC=1).
module tb_pc_ras;

  logic        clk;
  logic        rst_n;
  logic        en_in;
  logic [2:0]  ps_in;
  logic [15:0] ia_in;
  logic [15:0] ra_in;
  logic [15:0] vec_in;
  logic        err_clr_in;
  logic [15:0] pc_out;
  logic [2:0]  ras_cnt_out;
  logic        ras_full_out;
  logic        ras_empty_out;
  logic        ovf_err_out;
  logic        unf_err_out;

  int vectors;
  int miscompares;

  pc_ras #(
    .PC_W(16), .RAS_DEPTH(4), .RESET_PC(16'h0000), .INC(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en_in(en_in), .ps_in(ps_in),
    .ia_in(ia_in), .ra_in(ra_in), .vec_in(vec_in), .err_clr_in(err_clr_in),
    .pc_out(pc_out), .ras_cnt_out(ras_cnt_out), .ras_full_out(ras_full_out),
    .ras_empty_out(ras_empty_out), .ovf_err_out(ovf_err_out),
    .unf_err_out(unf_err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Apply one opcode for one clock edge; returns 1 time unit after the edge.
  task automatic step(input logic [2:0] op, input logic [15:0] ia, input logic [15:0] ra,
                      input logic [15:0] vec, input logic clr, input logic en);
    ps_in = op; ia_in = ia; ra_in = ra; vec_in = vec; err_clr_in = clr; en_in = en;
    @(posedge clk);
    #1;
    ps_in = 3'b000; err_clr_in = 1'b0; en_in = 1'b1;
  endtask

  task automatic jmp(input logic [15:0] tgt);
    step(3'b011, 16'h0, tgt, 16'h0, 1'b0, 1'b1);
  endtask

  task automatic call(input logic [15:0] off, input logic clr);
    step(3'b100, off, 16'h0, 16'h0, clr, 1'b1);
  endtask

  task automatic ret();
    step(3'b101, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1);
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst_n = 1'b0; en_in = 1'b0; ps_in = 3'b000; ia_in = '0; ra_in = '0;
    vec_in = '0; err_clr_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_cnt", ras_cnt_out, 32'd0);
    chk("rst_empty", ras_empty_out, 32'd1);
    chk("rst_full", ras_full_out, 32'd0);
    chk("rst_ovf", ovf_err_out, 32'd0);
    chk("rst_unf", unf_err_out, 32'd0);
    rst_n = 1'b1;

    // 1: sequential increment, then asynchronous reset without a clock edge
    for (int i = 1; i <= 3; i++) begin
      step(3'b001, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1);
      chk($sformatf("inc%0d", i), pc_out, 32'(i));
    end
    rst_n = 1'b0;
    #2;
    chk("async_rst_pc", pc_out, 32'h0);
    rst_n = 1'b1;

    // 2: negative branch and increment wrap
    jmp(16'h0010);
    chk("jmp_10", pc_out, 32'h10);
    step(3'b010, 16'hFFF0, 16'h0, 16'h0, 1'b0, 1'b1);
    chk("br_neg", pc_out, 32'h0);
    jmp(16'hFFFF);
    step(3'b001, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1);
    chk("inc_wrap", pc_out, 32'h0);

    // 3: single call / return
    jmp(16'h0020);
    call(16'h0100, 1'b0);
    chk("call_pc", pc_out, 32'h120);
    chk("call_cnt", ras_cnt_out, 32'd1);
    ret();
    chk("ret_pc", pc_out, 32'h21);
    chk("ret_cnt", ras_cnt_out, 32'd0);
    chk("ret_empty", ras_empty_out, 32'd1);

    // 4: overflow then underflow
    for (int i = 1; i <= 5; i++) begin
      jmp(16'(i * 16));
      call(16'h0, 1'b0);
      chk($sformatf("ovf_call%0d_pc", i), pc_out, 32'(i * 16));
      chk($sformatf("ovf_call%0d_cnt", i), ras_cnt_out, (i < 4) ? 32'(i) : 32'd4);
      chk($sformatf("ovf_call%0d_full", i), ras_full_out, (i >= 4) ? 32'd1 : 32'd0);
      chk($sformatf("ovf_call%0d_ovf", i), ovf_err_out, (i == 5) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      ret();
      chk($sformatf("pop%0d_pc", i), pc_out, 32'(16'h51 - 16'(i * 16)));
      chk($sformatf("pop%0d_cnt", i), ras_cnt_out, 32'(3 - i));
    end
    chk("pop_unf_before", unf_err_out, 32'd0);
    ret();
    chk("unf_pc", pc_out, 32'h22);
    chk("unf_flag", unf_err_out, 32'd1);
    chk("unf_cnt", ras_cnt_out, 32'd0);
    step(3'b000, 16'h0, 16'h0, 16'h0, 1'b1, 1'b1);
    chk("clr_ovf", ovf_err_out, 32'd0);
    chk("clr_unf", unf_err_out, 32'd0);

    // 5: interrupt entry / return, and stalls
    jmp(16'h0200);
    step(3'b110, 16'h0, 16'h0, 16'h0008, 1'b0, 1'b1);
    chk("irq_pc", pc_out, 32'h8);
    chk("irq_cnt", ras_cnt_out, 32'd1);
    step(3'b001, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    chk("stall_inc_pc", pc_out, 32'h8);
    step(3'b101, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    chk("stall_ret_pc", pc_out, 32'h8);
    chk("stall_ret_cnt", ras_cnt_out, 32'd1);
    ret();
    chk("irq_ret_pc", pc_out, 32'h200);
    chk("irq_ret_cnt", ras_cnt_out, 32'd0);

    // 6: set beats clear, stall ignores clear, clear on HOLD, reserved opcode
    for (int i = 0; i < 5; i++) call(16'h0, 1'b0);
    chk("fill_ovf", ovf_err_out, 32'd1);
    call(16'h0, 1'b1);
    chk("set_wins", ovf_err_out, 32'd1);
    step(3'b000, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0);
    chk("stall_clr_ignored", ovf_err_out, 32'd1);
    step(3'b000, 16'h0, 16'h0, 16'h0, 1'b1, 1'b1);
    chk("hold_clr", ovf_err_out, 32'd0);
    step(3'b111, 16'h0040, 16'h1234, 16'h5678, 1'b0, 1'b1);
    chk("rsvd_pc", pc_out, 32'h200);
    chk("rsvd_cnt", ras_cnt_out, 32'd4);
    chk("rsvd_ovf", ovf_err_out, 32'd0);
    chk("rsvd_unf", unf_err_out, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
